// File: rtl/gds_pkg.sv
// Shared constants, channel-index width helper and scheduler state type for gray_dec_sched.
package gds_pkg;

  localparam int unsigned GDS_NCH = 32;
  localparam int unsigned GDS_W   = 12;

  function automatic int unsigned gds_chw(input int unsigned nch);
    return (nch <= 2) ? 1 : unsigned'($clog2(nch));
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StHold
  } gds_state_t;

endpackage

// File: rtl/gray_dec_sched_dec.sv
// Purely combinational W-bit Gray-to-binary decoder (module gray_dec_w).
module gray_dec_w
  import gds_pkg::*;
#(
  parameter int unsigned W = GDS_W
) (
  input  logic [W-1:0] g_i,
  output logic [W-1:0] bin_o
);

  // bin[k] is the XOR of all Gray bits at or above k.
  always_comb begin
    bin_o = '0;
    for (int unsigned k = 0; k < W; k++) begin
      bin_o[k] = ^(g_i >> k);
    end
  end

endmodule

// File: rtl/gray_dec_sched.sv
// Round-robin scheduler sharing one Gray-to-binary decoder among NCH requesters.
// Optional step-error check on consecutive samples per channel: define GDS_JUMP_CHK_EN.
module gray_dec_sched
  import gds_pkg::*;
#(
  parameter  int unsigned NCH      = GDS_NCH,
  parameter  int unsigned W        = GDS_W,
  parameter  int unsigned MAX_STEP = 1,
  localparam int unsigned CHW      = gds_chw(NCH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NCH-1:0]   req_i,
  input  logic [NCH*W-1:0] gray_in_i,
  output logic [NCH-1:0]   gnt_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CHW-1:0]   out_ch_o,
  output logic [W-1:0]     out_bin_o,
  output logic             out_jump_o
);

  gds_state_t     state_q;
  logic [CHW-1:0] ptr_q, ch_q, out_ch_q;
  logic [W-1:0]   hold_q, out_bin_q;
  logic           out_valid_q, out_jump_q;

  logic [CHW-1:0] win_idx, ptr_nxt;
  logic [W-1:0]   gray_sel, bin;
  logic           win_found, arb_en, grant, jump_d;

  // First requester at or above ptr, wrapping at NCH-1.
  always_comb begin : arb_search
    logic [CHW:0] sum;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      sum = {1'b0, ptr_q} + (CHW+1)'(k);
      if (sum >= (CHW+1)'(NCH)) begin
        sum = sum - (CHW+1)'(NCH);
      end
      if (!win_found && req_i[sum[CHW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[CHW-1:0];
      end
    end
  end

  assign arb_en   = (state_q == StIdle) ||
                    ((state_q == StHold) && out_valid_q && out_ready_i);
  assign grant    = rst_ni && arb_en && win_found;
  assign ptr_nxt  = (win_idx == CHW'(NCH - 1)) ? '0 : win_idx + 1'b1;
  assign gray_sel = gray_in_i[win_idx*W +: W];

  always_comb begin
    gnt_o = '0;
    if (grant) begin
      gnt_o[win_idx] = 1'b1;
    end
  end

  gray_dec_w #(
    .W (W)
  ) u_dec (
    .g_i   (hold_q),
    .bin_o (bin)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      ch_q        <= '0;
      hold_q      <= '0;
      out_ch_q    <= '0;
      out_bin_q   <= '0;
      out_valid_q <= 1'b0;
      out_jump_q  <= 1'b0;
    end else begin
      if (grant) begin
        hold_q <= gray_sel;
        ch_q   <= win_idx;
        ptr_q  <= ptr_nxt;
      end
      case (state_q)
        StIdle: begin
          if (grant) state_q <= StConv;
        end
        StConv: begin
          out_bin_q   <= bin;
          out_ch_q    <= ch_q;
          out_jump_q  <= jump_d;
          out_valid_q <= 1'b1;
          state_q     <= StHold;
        end
        StHold: begin
          if (out_valid_q && out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= grant ? StConv : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef GDS_JUMP_CHK_EN
  logic [W-1:0]   last_q [NCH];
  logic [NCH-1:0] seen_q;
  logic [W-1:0]   diff, diff_neg, step;

  // Circular distance: the shorter way round the 2^W ring.
  always_comb begin
    diff     = bin - last_q[ch_q];
    diff_neg = '0 - diff;
    step     = (diff < diff_neg) ? diff : diff_neg;
    jump_d   = seen_q[ch_q] && (32'(step) > MAX_STEP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seen_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        last_q[i] <= '0;
      end
    end else if (state_q == StConv) begin
      last_q[ch_q] <= bin;
      seen_q[ch_q] <= 1'b1;
    end
  end
`else
  logic unused_max_step;
  assign unused_max_step = ^MAX_STEP;
  assign jump_d          = 1'b0;
`endif

  assign out_valid_o = out_valid_q;
  assign out_ch_o    = out_ch_q;
  assign out_bin_o   = out_bin_q;
  assign out_jump_o  = out_jump_q;

endmodule

// File: doc/gray_dec_sched.md
Name: gray_dec_sched

Overview:
- Round-robin scheduler that shares one W-bit Gray-to-binary decoder among NCH channel requesters.
- Grants one channel per conversion, latches its Gray word and presents the binary result with the channel index on a valid/ready output port.
- Sits between the 32-channel encoder-position capture logic and the downstream packet/telemetry formatter.

Parameters:
- NCH, 32, number of requesting channels (2..64; need not be a power of 2)
- W, 12, Gray/binary word width (2..16)
- MAX_STEP, 1, largest legal circular step between consecutive samples of one channel; used only when GDS_JUMP_CHK_EN is defined

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NCH  per-channel conversion request, level, held until granted
- gray_in  in  NCH*W  flattened Gray words; channel i occupies bits [i*W +: W]
- gnt  out  NCH  one-hot, one-cycle grant pulse; the slice is captured in this cycle
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_ch  out  CHW  channel index of the result; CHW = max(1, $clog2(NCH))
- out_bin  out  W  decoded binary value
- out_jump  out  1  step-error flag, qualified by out_valid

Behaviour:
- Reset (asynchronous, any state): gnt=0, out_valid=0, out_ch=0, out_bin=0, out_jump=0, ptr=0, state=IDLE, hold register=0.
- States: IDLE, CONV, HOLD.
- Arbitration is combinational in IDLE, or in HOLD when the output handshake completes:
  - Winner = first i with req[i]=1, searching from ptr upward and wrapping at NCH-1 to 0.
  - gnt[winner]=1 for that cycle only.
  - gray_in slice and winner index are registered.
  - ptr <= winner+1; wraps to 0 when winner=NCH-1.
  - state -> CONV.
- IDLE with no req: gnt=0, remain in IDLE.
- CONV:
  - out_bin <= bin[W-1]=G[W-1]; bin[k]=bin[k+1]^G[k].
  - out_ch <= latched index; out_valid <= 1; state -> HOLD.
  - No grant is issued in CONV.
- HOLD:
  - out_valid, out_ch, out_bin and out_jump are held stable until out_valid&&out_ready.
  - On that handshake: if any req, arbitrate in the same cycle (back-to-back) and go to CONV, with out_valid <= 0; otherwise out_valid <= 0 and go to IDLE.
- Latency and throughput:
  - req sampled with gnt at cycle T gives out_valid at T+2.
  - Peak throughput is one result per 2 cycles with out_ready held at 1.
- Requester contract:
  - gray_in[i] must be stable in the gnt[i] cycle.
  - Dropping req[i] before grant cancels the request with no side effect.
  - req[i] held after grant is treated as a new request and is served again after the other active channels.
- Fairness: any continuously asserted request is granted within NCH grants.
- Simultaneous requests: the lowest index at or above ptr wins.
- out_ready high while out_valid=0 is ignored.
- Reset mid-operation: a pending result is discarded and the granted request is lost. Requesters re-issue on reset release.

Optional Feature:
- Macro GDS_JUMP_CHK_EN.
- Defined:
  - Keep a per-channel last-value array (NCH x W) plus a per-channel seen bit, all cleared at reset.
  - In CONV, d = (new - last) mod 2^W; step = min(d, 2^W - d).
  - out_jump <= seen[ch] && (step > MAX_STEP).
  - Then last[ch] <= new and seen[ch] <= 1.
  - The first sample of a channel after reset never flags.
- Undefined: out_jump is tied to 0 and no array or seen bits are instantiated. The port stays present so the interface does not change.

Decomposition:
- Shared package gds_pkg holds:
  - default constants GDS_NCH=32, GDS_W=12;
  - function gds_chw(nch) returning max(1, $clog2(nch));
  - state enum gds_state_t {IDLE, CONV, HOLD}.
- One sub-module gray_dec_w: purely combinational, parameter W, input G[W-1:0], output bin[W-1:0]. Instantiated once on the hold register.
- The round-robin search stays inline in gray_dec_sched.

Test Plan:
- Single request: req[5]=1 with gray_in[5]=12'h800 -> gnt[5] pulse at T; out_valid at T+2 with out_ch=5, out_bin=12'hFFF.
- All 32 requests held, out_ready=1 -> grants in order 0,1,...,31,0. Results every 2 cycles, each out_bin equal to the reference decode.
- Backpressure: out_ready=0 for 10 cycles -> outputs stable, no gnt issued. Release -> handshake plus next gnt in the same cycle.
- Wrap and fairness: ptr=31 with req[31] and req[0] -> 31 granted first, then 0. Also repeat with NCH=5 to check the non-power-of-2 wrap.
- Async reset asserted in CONV -> all outputs 0 immediately. After release, IDLE with ptr=0.
- With GDS_JUMP_CHK_EN, MAX_STEP=1, channel 3:
  - binary sequence 4095, 0, 2 -> out_jump 0, 0, 1 (the 4095->0 wrap is legal);
  - first sample after reset -> out_jump 0.
